cmo_dc_ctrl: RTL and testbench



---
 rtl/ariane_pkg.sv | 77 +++++++
 rtl/cmo_dc_ctrl_if.sv | 27 ++
 rtl/cmo_sweep_cnt.sv | 57 +++++
 rtl/cmo_dc_ctrl.sv | 139 +++++++++++++
 tb/tb_cmo_dc_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// CMO request/response types, line-op encoding and CMO decode helpers
// shared by the D-cache CMO controller.
package ariane_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        CMO_CLEAN      = 4'd0,
        CMO_FLUSH      = 4'd1,
        CMO_INVAL      = 4'd2,
        CMO_ZERO       = 4'd3,
        CMO_PREFETCH_R = 4'd4,
        CMO_PREFETCH_W = 4'd5,
        CMO_PREFETCH_I = 4'd6,
        CMO_CLEAN_ALL  = 4'd7,
        CMO_FLUSH_ALL  = 4'd8,
        CMO_INVAL_ALL  = 4'd9,
        CMO_NONE       = 4'd10
    } cmo_t;

    typedef enum logic [1:0] {
        CMO_LINE_CLEAN = 2'd0,
        CMO_LINE_FLUSH = 2'd1,
        CMO_LINE_INVAL = 2'd2,
        CMO_LINE_ZERO  = 2'd3
    } cmo_line_op_t;

    typedef enum logic [2:0] {
        CMO_IDLE       = 3'd0,
        CMO_LINE_REQ   = 3'd1,
        CMO_LINE_WAIT  = 3'd2,
        CMO_SWEEP_REQ  = 3'd3,
        CMO_SWEEP_WAIT = 3'd4,
        CMO_ACK        = 3'd5
    } cmo_state_t;

    typedef struct packed {
        logic                     req;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          address;
        cmo_t                     cmo_op;
    } cmo_req_t;

    typedef struct packed {
        logic                     req_ready;
        logic                     ack;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } cmo_resp_t;

    function automatic cmo_line_op_t cmo_to_line_op(input cmo_t op);
        cmo_line_op_t res;
        case (op)
            CMO_FLUSH, CMO_FLUSH_ALL: res = CMO_LINE_FLUSH;
            CMO_INVAL, CMO_INVAL_ALL: res = CMO_LINE_INVAL;
            CMO_ZERO:                 res = CMO_LINE_ZERO;
            default:                  res = CMO_LINE_CLEAN;
        endcase
        return res;
    endfunction

    function automatic logic cmo_is_sweep(input cmo_t op);
        return (op == CMO_CLEAN_ALL) || (op == CMO_FLUSH_ALL) || (op == CMO_INVAL_ALL);
    endfunction

    // Anything that is neither a per-line nor a sweep op is treated as a hint.
    function automatic logic cmo_is_hint(input cmo_t op);
        logic res;
        case (op)
            CMO_CLEAN, CMO_FLUSH, CMO_INVAL, CMO_ZERO,
            CMO_CLEAN_ALL, CMO_FLUSH_ALL, CMO_INVAL_ALL: res = 1'b0;
            default:                                     res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmo_dc_ctrl_if.sv
// Line-operation channel between the CMO controller and the D-cache.
interface cmo_dc_ctrl_if
    import ariane_pkg::*;
#(
    parameter int unsigned AW = 64,
    parameter int unsigned SW = 8,
    parameter int unsigned WW = 3
);
    logic           line_req;
    cmo_line_op_t   line_op;
    logic           line_by_addr;
    logic [AW-1:0]  line_addr;
    logic [SW-1:0]  line_set;
    logic [WW-1:0]  line_way;
    logic           line_gnt;
    logic           line_done;

    modport master (
        output line_req, line_op, line_by_addr, line_addr, line_set, line_way,
        input  line_gnt, line_done
    );

    modport slave (
        input  line_req, line_op, line_by_addr, line_addr, line_set, line_way,
        output line_gnt, line_done
    );
endinterface

// File: rtl/cmo_sweep_cnt.sv
// Set/way sweep counter: way-minor, set-major; last flags the final line.
module cmo_sweep_cnt #(
    parameter int unsigned NUM_SETS = 256,
    parameter int unsigned NUM_WAYS = 8,
    localparam int unsigned SET_W = $clog2(NUM_SETS),
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [SET_W-1:0] set_o,
    output logic [WAY_W-1:0] way_o,
    output logic             last_o
);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0] WAY_MAX = WAY_W'(NUM_WAYS - 1);

    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic             last_q, last_d;

    always_comb begin
        set_d  = set_q;
        way_d  = way_q;
        last_d = last_q;
        if (clear_i) begin
            set_d  = '0;
            way_d  = '0;
            last_d = 1'b0;
        end else if (advance_i) begin
            if (way_q == WAY_MAX) begin
                way_d = '0;
                set_d = set_q + SET_W'(1);
            end else begin
                way_d = way_q + WAY_W'(1);
            end
            last_d = (set_d == SET_MAX) && (way_d == WAY_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q  <= '0;
            way_q  <= '0;
            last_q <= 1'b0;
        end else begin
            set_q  <= set_d;
            way_q  <= way_d;
            last_q <= last_d;
        end
    end

    assign set_o  = set_q;
    assign way_o  = way_q;
    assign last_o = last_q;
endmodule

// File: rtl/cmo_dc_ctrl.sv
// D-cache CMO controller: turns CMO requests into single-line operations
// or full set/way sweeps and acknowledges the CMO unit on completion.
module cmo_dc_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_SETS    = 256,
    parameter int unsigned NUM_WAYS    = 8,
    parameter int unsigned LINE_OFFSET = 4,
    localparam int unsigned SET_W = $clog2(NUM_SETS),
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  cmo_req_t         cmo_req_i,
    output cmo_resp_t        cmo_resp_o,
    output logic             line_req_o,
    output cmo_line_op_t     line_op_o,
    output logic             line_by_addr_o,
    output logic [XLEN-1:0]  line_addr_o,
    output logic [SET_W-1:0] line_set_o,
    output logic [WAY_W-1:0] line_way_o,
    input  logic             line_gnt_i,
    input  logic             line_done_i,
    output logic             busy_o
);
    localparam logic [XLEN-1:0] LINE_MASK = ~((XLEN'(1) << LINE_OFFSET) - XLEN'(1));

    cmo_state_t               state_q, state_d;
    cmo_t                     op_q;
    logic [TRANS_ID_BITS-1:0] tid_q;
    logic [XLEN-1:0]          addr_q;
    logic                     accept;
    logic                     cnt_clear, cnt_adv, cnt_last;

    assign accept = (state_q == CMO_IDLE) && cmo_req_i.req;

    cmo_sweep_cnt #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_sweep_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (cnt_clear),
        .advance_i (cnt_adv),
        .set_o     (line_set_o),
        .way_o     (line_way_o),
        .last_o    (cnt_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= CMO_IDLE;
        else         state_q <= state_d;
    end

    // A done arriving together with gnt completes the line in that same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            CMO_IDLE: begin
                if (cmo_req_i.req) begin
                    if (cmo_is_hint(cmo_req_i.cmo_op)) begin
                        state_d = CMO_ACK;
                    end else if (cmo_is_sweep(cmo_req_i.cmo_op)) begin
                        state_d   = CMO_SWEEP_REQ;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = CMO_LINE_REQ;
                    end
                end
            end
            CMO_LINE_REQ: begin
                if (line_gnt_i) state_d = line_done_i ? CMO_ACK : CMO_LINE_WAIT;
            end
            CMO_LINE_WAIT: begin
                if (line_done_i) state_d = CMO_ACK;
            end
            CMO_SWEEP_REQ: begin
                if (line_gnt_i) begin
                    if (line_done_i) begin
                        cnt_adv = 1'b1;
                        state_d = cnt_last ? CMO_ACK : CMO_SWEEP_REQ;
                    end else begin
                        state_d = CMO_SWEEP_WAIT;
                    end
                end
            end
            CMO_SWEEP_WAIT: begin
                if (line_done_i) begin
                    cnt_adv = 1'b1;
                    state_d = cnt_last ? CMO_ACK : CMO_SWEEP_REQ;
                end
            end
            CMO_ACK: state_d = CMO_IDLE;
            default: state_d = CMO_IDLE;
        endcase
    end

    always_comb begin
        cmo_resp_o     = '0;
        line_req_o     = 1'b0;
        line_by_addr_o = 1'b0;
        busy_o         = 1'b1;
        unique case (state_q)
            CMO_IDLE: begin
                cmo_resp_o.req_ready = 1'b1;
                busy_o               = 1'b0;
            end
            CMO_LINE_REQ: begin
                line_req_o     = 1'b1;
                line_by_addr_o = 1'b1;
            end
            CMO_LINE_WAIT:  line_by_addr_o = 1'b1;
            CMO_SWEEP_REQ:  line_req_o     = 1'b1;
            CMO_SWEEP_WAIT: line_req_o     = 1'b0;
            CMO_ACK: begin
                cmo_resp_o.ack      = 1'b1;
                cmo_resp_o.trans_id = tid_q;
            end
            default: busy_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= CMO_CLEAN;
            tid_q  <= '0;
            addr_q <= '0;
        end else if (accept) begin
            op_q   <= cmo_req_i.cmo_op;
            tid_q  <= cmo_req_i.trans_id;
            addr_q <= cmo_req_i.address & LINE_MASK;
        end
    end

    assign line_op_o   = cmo_to_line_op(op_q);
    assign line_addr_o = addr_q;
endmodule

// File: tb/tb_cmo_dc_ctrl.sv
// Directed, table-driven bench for cmo_dc_ctrl with a 4-set, 2-way cache
// responder that applies per-vector grant and done delays.
module tb_cmo_dc_ctrl;
    import ariane_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned WW = 1;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    cmo_req_t  cmo_req;
    cmo_resp_t cmo_resp;
    logic      busy;

    always #5 clk = ~clk;

    cmo_dc_ctrl_if #(.AW(XLEN), .SW(SW), .WW(WW)) line_if ();

    cmo_dc_ctrl #(
        .NUM_SETS    (NS),
        .NUM_WAYS    (NW),
        .LINE_OFFSET (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmo_req_i      (cmo_req),
        .cmo_resp_o     (cmo_resp),
        .line_req_o     (line_if.line_req),
        .line_op_o      (line_if.line_op),
        .line_by_addr_o (line_if.line_by_addr),
        .line_addr_o    (line_if.line_addr),
        .line_set_o     (line_if.line_set),
        .line_way_o     (line_if.line_way),
        .line_gnt_i     (line_if.line_gnt),
        .line_done_i    (line_if.line_done),
        .busy_o         (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        string        name;
        cmo_t         op;
        logic [63:0]  addr;
        logic [2:0]   tid;
        int           g;      // request cycles without grant
        int           d;      // cycles from grant to done (0 = same cycle)
        int           lines;  // expected line operations
        cmo_line_op_t eop;
        logic [63:0]  eaddr;
        int           lat;    // accept cycle to ack cycle
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input string n, input cmo_t op, input logic [63:0] a,
                                input logic [2:0] t, input int g, input int d, input int l,
                                input cmo_line_op_t eop, input logic [63:0] ea, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.addr = a; v.tid = t; v.g = g; v.d = d;
        v.lines = l; v.eop = eop; v.eaddr = ea; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lines = 0;
        int rcnt  = 0;
        int wcnt  = 0;
        bit acked = 1'b0;
        bit sweep;
        sweep = (v.lines > 1);
        chk({v.name, ":ready_before"}, 64'(cmo_resp.req_ready), 64'(1));
        cmo_req.req      = 1'b1;
        cmo_req.cmo_op   = v.op;
        cmo_req.address  = v.addr;
        cmo_req.trans_id = v.tid;
        step();
        cmo_req = '0;
        for (int c = 1; c <= 200 && !acked; c++) begin
            line_if.line_gnt  = 1'b0;
            line_if.line_done = 1'b0;
            if (cmo_resp.ack) begin
                chk({v.name, ":ack_lat"}, 64'(c), 64'(v.lat));
                chk({v.name, ":ack_tid"}, 64'(cmo_resp.trans_id), 64'(v.tid));
                chk({v.name, ":lines"}, 64'(lines), 64'(v.lines));
                chk({v.name, ":ready_in_ack"}, 64'(cmo_resp.req_ready), 64'(0));
                acked = 1'b1;
            end else begin
                chk({v.name, ":busy_ready_tid"},
                    64'({busy, cmo_resp.req_ready, cmo_resp.trans_id}), 64'(5'b10000));
                if (line_if.line_req) begin
                    chk({v.name, ":line_op"}, 64'(line_if.line_op), 64'(v.eop));
                    chk({v.name, ":by_addr"}, 64'(line_if.line_by_addr), 64'(!sweep));
                    if (sweep) begin
                        chk({v.name, ":set"}, 64'(line_if.line_set), 64'(lines / NW));
                        chk({v.name, ":way"}, 64'(line_if.line_way), 64'(lines % NW));
                    end else begin
                        chk({v.name, ":addr"}, line_if.line_addr, v.eaddr);
                    end
                    if (rcnt == v.g) begin
                        line_if.line_gnt = 1'b1;
                        lines++;
                        rcnt = 0;
                        if (v.d == 0) line_if.line_done = 1'b1;
                        else          wcnt = v.d;
                    end else begin
                        rcnt++;
                    end
                end else if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) line_if.line_done = 1'b1;
                end
            end
            step();
        end
        line_if.line_gnt  = 1'b0;
        line_if.line_done = 1'b0;
        if (!acked) chk({v.name, ":ack_timeout"}, 64'(0), 64'(1));
        chk({v.name, ":ready_after_ack"}, 64'({cmo_resp.req_ready, cmo_resp.ack}), 64'(2'b10));
    endtask

    task automatic chk_reset_outs(input string n);
        chk({n, ":resp"}, 64'({cmo_resp.req_ready, cmo_resp.ack, cmo_resp.trans_id}), 64'(5'b10000));
        chk({n, ":line_ctl"}, 64'({line_if.line_req, line_if.line_by_addr, busy}), 64'(0));
        chk({n, ":line_op"}, 64'(line_if.line_op), 64'(0));
        chk({n, ":line_addr"}, line_if.line_addr, 64'(0));
        chk({n, ":set_way"}, 64'({line_if.line_set, line_if.line_way}), 64'(0));
    endtask

    initial begin
        bit hit;
        vecs[0] = mk("flush_line", CMO_FLUSH,      64'h8000_123C,          3'd5, 1,  3, 1, CMO_LINE_FLUSH, 64'h8000_1230,          6);
        vecs[1] = mk("inval_all",  CMO_INVAL_ALL,  64'h0,                  3'd2, 0,  0, 8, CMO_LINE_INVAL, 64'h0,                  9);
        vecs[2] = mk("prefetch_w", CMO_PREFETCH_W, 64'h1234,               3'd3, 0,  0, 0, CMO_LINE_CLEAN, 64'h0,                  1);
        vecs[3] = mk("clean_imm",  CMO_CLEAN,      64'hFF,                 3'd1, 0,  0, 1, CMO_LINE_CLEAN, 64'hF0,                 2);
        vecs[4] = mk("zero_stall", CMO_ZERO,       64'h1000_0007,          3'd7, 10, 1, 1, CMO_LINE_ZERO,  64'h1000_0000,          13);
        vecs[5] = mk("none",       CMO_NONE,       64'h0,                  3'd4, 0,  0, 0, CMO_LINE_CLEAN, 64'h0,                  1);
        vecs[6] = mk("clean_all",  CMO_CLEAN_ALL,  64'h0,                  3'd6, 1,  2, 8, CMO_LINE_CLEAN, 64'h0,                  33);
        vecs[7] = mk("flush_all",  CMO_FLUSH_ALL,  64'h0,                  3'd1, 0,  1, 8, CMO_LINE_FLUSH, 64'h0,                  17);
        vecs[8] = mk("inval_line", CMO_INVAL,      64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 0, 2, 1, CMO_LINE_INVAL, 64'hFFFF_FFFF_FFFF_FFF0, 4);

        cmo_req           = '0;
        line_if.line_gnt  = 1'b0;
        line_if.line_done = 1'b0;
        #3;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_reset_outs("post_reset");

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a sweep, once set 2 is being requested
        cmo_req.req      = 1'b1;
        cmo_req.cmo_op   = CMO_INVAL_ALL;
        cmo_req.trans_id = 3'd6;
        step();
        cmo_req = '0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            line_if.line_gnt  = 1'b0;
            line_if.line_done = 1'b0;
            if (line_if.line_req && line_if.line_set == 2'd2) begin
                hit = 1'b1;
                break;
            end
            if (line_if.line_req) begin
                line_if.line_gnt  = 1'b1;
                line_if.line_done = 1'b1;
            end
            step();
        end
        chk("rst_sweep:reached_set2", 64'(hit), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_sweep");
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_sweep:no_ack", 64'(cmo_resp.ack), 64'(0));
        end
        rst_n = 1'b1;
        step();
        run_vec(mk("clean_after_rst", CMO_CLEAN, 64'h4000_0044, 3'd3, 0, 1, 1,
                   CMO_LINE_CLEAN, 64'h4000_0040, 3));

        // Spurious done while idle must not leak into the next request
        line_if.line_done = 1'b1;
        step();
        chk("spurious:ack0", 64'({cmo_resp.ack, busy}), 64'(0));
        step();
        line_if.line_done = 1'b0;
        chk("spurious:ack1", 64'({cmo_resp.ack, busy}), 64'(0));
        run_vec(mk("clean_after_spurious", CMO_CLEAN, 64'h2000_0018, 3'd5, 2, 2, 1,
                   CMO_LINE_CLEAN, 64'h2000_0010, 6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
